// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves memory-wait,
// redirect, load-use and fetch-wait hazards in fixed priority, plus counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_read,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_enable,
    input  logic                  ex_is_load,
    input  logic                  ex_redirect,
    input  logic                  mem_busy,
    input  logic                  if_busy,
    output logic [4:0]            stall,
    output logic [4:0]            flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  mem_timeout
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WMAX    = WW'(MEM_TIMEOUT);
    localparam logic [WW:0]   WTRIG   = (WW+1)'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FW-1:0]     r_fcnt;
    logic [FW-1:0]     w_fcnt_nxt;
    logic [WW-1:0]     r_wcnt;
    logic [WW:0]       w_wcnt_inc;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              r_mem_timeout;
    logic [4:0]        w_stall;
    logic [4:0]        w_flush;
    logic              w_load_use;
    logic              w_rs1_hit;
    logic              w_rs2_hit;

    assign w_rs1_hit  = id_rs1_read && (id_rs1_addr == ex_rd_addr);
    assign w_rs2_hit  = id_rs2_read && (id_rs2_addr == ex_rd_addr);
    assign w_load_use = ex_is_load && ex_rd_enable && (ex_rd_addr != '0)
                        && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Priority chain; lower-priority branches leave the flush window untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_stall     = 5'b00000;
        w_flush     = 5'b00000;
        if (mem_busy) begin
            w_stall = 5'b01111;
            w_flush = 5'b10000;
        end else if (ex_redirect) begin
            w_flush = 5'b00110;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = FRELOAD;
            end
        end else if (w_load_use) begin
            w_stall = 5'b00011;
            w_flush = 5'b00100;
        end else if (r_state == ST_FLUSH) begin
            w_flush    = 5'b00010;
            w_fcnt_nxt = r_fcnt - 1'b1;
            if (r_fcnt == FW'(1)) begin
                w_state_nxt = ST_RUN;
            end
        end else if (if_busy) begin
            w_stall = 5'b00001;
            w_flush = 5'b00010;
        end
    end

    assign stall = rst ? w_stall : 5'b00000;
    assign flush = rst ? w_flush : 5'b00000;

    assign w_wcnt_inc = {1'b0, r_wcnt} + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            if (r_wcnt != WMAX) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_wcnt_inc == WTRIG) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if ((|w_stall) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner
// sequences and randomized traffic against an integer reference model.
module tb_pipe_hazard_ctrl;

    localparam int FC    = 2;
    localparam int MT    = 4;
    localparam int CW    = 8;
    localparam int SCMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1_addr = '0;
    logic          id_rs1_read = 1'b0;
    logic [4:0]    id_rs2_addr = '0;
    logic          id_rs2_read = 1'b0;
    logic [4:0]    ex_rd_addr = '0;
    logic          ex_rd_enable = 1'b0;
    logic          ex_is_load = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          mem_busy = 1'b0;
    logic          if_busy = 1'b0;
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic [CW-1:0] stall_cycles;
    logic          mem_timeout;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: remaining flush-window cycles, busy streak, stall count, sticky flag.
    int m_fl = 0;
    int m_wc = 0;
    int m_sc = 0;
    bit m_to = 1'b0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs1_read (id_rs1_read),
        .id_rs2_addr (id_rs2_addr),
        .id_rs2_read (id_rs2_read),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_enable(ex_rd_enable),
        .ex_is_load  (ex_is_load),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .if_busy     (if_busy),
        .stall       (stall),
        .flush       (flush),
        .stall_cycles(stall_cycles),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1; logic r1; logic [4:0] a2; logic r2;
        logic [4:0] rd; logic rde; logic ld; logic rdr; logic mb; logic ib;
        logic [4:0] es; logic [4:0] ef;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic r1, input logic [4:0] a2,
                         input logic r2, input logic [4:0] rd, input logic rde,
                         input logic ld, input logic rdr, input logic mb, input logic ib);
        id_rs1_addr = a1; id_rs1_read = r1; id_rs2_addr = a2; id_rs2_read = r2;
        ex_rd_addr = rd; ex_rd_enable = rde; ex_is_load = ld;
        ex_redirect = rdr; mem_busy = mb; if_busy = ib;
    endtask

    // One clock: drive, check combinational outputs against the model (and
    // optionally against literal expectations), clock, then check counters.
    task automatic cyc(input logic [4:0] a1, input logic r1, input logic [4:0] a2,
                       input logic r2, input logic [4:0] rd, input logic rde,
                       input logic ld, input logic rdr, input logic mb, input logic ib,
                       input logic use_k, input logic [4:0] es, input logic [4:0] ef,
                       input string nm);
        logic [4:0] ms, mf;
        bit lu;
        @(negedge clk);
        drive(a1, r1, a2, r2, rd, rde, ld, rdr, mb, ib);
        #1;
        lu = ld && rde && (rd != 0) && ((r1 && a1 == rd) || (r2 && a2 == rd));
        ms = 5'b00000; mf = 5'b00000;
        if (mb)            begin ms = 5'b01111; mf = 5'b10000; end
        else if (rdr)      begin mf = 5'b00110; end
        else if (lu)       begin ms = 5'b00011; mf = 5'b00100; end
        else if (m_fl > 0) begin mf = 5'b00010; end
        else if (ib)       begin ms = 5'b00001; mf = 5'b00010; end
        chk({nm, "_stall"}, 32'(stall), 32'(ms));
        chk({nm, "_flush"}, 32'(flush), 32'(mf));
        if (use_k) begin
            chk({nm, "_stall_k"}, 32'(stall), 32'(es));
            chk({nm, "_flush_k"}, 32'(flush), 32'(ef));
        end
        @(posedge clk);
        if (!mb) begin
            if (rdr)           m_fl = FC - 1;
            else if (!lu && m_fl > 0) m_fl = m_fl - 1;
        end
        if (mb) begin
            if (m_wc + 1 == MT) m_to = 1'b1;
            if (m_wc < MT) m_wc = m_wc + 1;
        end else begin
            m_wc = 0;
        end
        if (ms != 0 && m_sc < SCMAX) m_sc = m_sc + 1;
        #1;
        chk({nm, "_cnt"}, 32'(stall_cycles), 32'(m_sc));
        chk({nm, "_wdog"}, 32'(mem_timeout), 32'(m_to));
    endtask

    task automatic idle(input string nm);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 5'b0, 5'b0, nm);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        m_fl = 0; m_wc = 0; m_sc = 0; m_to = 1'b0;
        #1;
        chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_async_wdog", 32'(mem_timeout), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), (i == 0) ? 1'b1 : 1'($urandom),
                  1'($urandom));
            #1;
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
            chk("rst_cnt", 32'(stall_cycles), 32'd0);
            chk("rst_wdog", 32'(mem_timeout), 32'd0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        tbl[0]  = '{5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00100};
        tbl[1]  = '{5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00100};
        tbl[2]  = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[3]  = '{5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[4]  = '{5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[5]  = '{5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[6]  = '{5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[7]  = '{5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00110};
        tbl[8]  = '{5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b01111, 5'b10000};
        tbl[9]  = '{5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00011, 5'b00100};
        tbl[10] = '{5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00010};
        tbl[11] = '{5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01111, 5'b10000};

        #3;
        do_reset(3);

        // Load-use: one bubble, then clear; rd=x0 never stalls.
        cyc(5'd1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00011, 5'b00100, "lu");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'b00000, 5'b00000, "lu_after");
        cyc(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, "lu_x0");

        // Redirect pulse opens a two-cycle IF/ID flush window.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b1, 5'b00000, 5'b00110, "rd_c0");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'b00000, 5'b00010, "rd_c1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'b00000, 5'b00000, "rd_c2");

        // Redirect held under mem_busy is re-presented once memory is ready.
        base = m_sc;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1'b1, 5'b01111, 5'b10000, "mbrd_busy");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b1, 5'b00000, 5'b00110, "mbrd_go");
        chk("mbrd_cnt3", 32'(stall_cycles), 32'(base + 3));
        idle("mbrd_d0");
        idle("mbrd_d1");

        // Fetch wait in RUN, masked during the flush window.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1, 5'b00001, 5'b00010, "ifb0");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1, 5'b00001, 5'b00010, "ifb1");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1'b1, 5'b00000, 5'b00110, "ifb_rd");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1, 5'b00000, 5'b00010, "ifb_mask");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1, 5'b00001, 5'b00010, "ifb_run");

        // Redirect inside the window restarts it.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b1, 5'b00000, 5'b00110, "rr0");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b1, 5'b00000, 5'b00110, "rr1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'b00000, 5'b00010, "rr2");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'b00000, 5'b00000, "rr3");

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].a1, tbl[i].r1, tbl[i].a2, tbl[i].r2, tbl[i].rd, tbl[i].rde,
                tbl[i].ld, tbl[i].rdr, tbl[i].mb, tbl[i].ib, 1'b1, tbl[i].es, tbl[i].ef,
                $sformatf("tbl%0d", i));
            idle("tbl_d0");
            idle("tbl_d1");
        end

        // Watchdog: fourth consecutive busy edge sets the sticky flag.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b1, 5'b01111, 5'b10000, "wd_busy");
            if (i == 2) chk("wd_not_yet", 32'(mem_timeout), 32'd0);
        end
        chk("wd_set", 32'(mem_timeout), 32'd1);
        idle("wd_i0");
        idle("wd_i1");
        chk("wd_sticky", 32'(mem_timeout), 32'd1);

        // Stall counter saturates at all-ones.
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 5'b0, 5'b0, "sat");
        end
        chk("cnt_sat", 32'(stall_cycles), 32'(SCMAX));

        do_reset(2);
        chk("rst2_cnt", 32'(stall_cycles), 32'd0);
        chk("rst2_wdog", 32'(mem_timeout), 32'd0);

        for (int i = 0; i < 500; i++) begin
            cyc(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), 1'b0, 5'b0, 5'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
